// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response/burst encodings and engine state types for axi_mem_slave
package axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

endpackage

// File: rtl/axi_mem_ram.sv
// rtl/axi_mem_ram.sv - DEPTH x DATA_WIDTH word array, async read port, sync write port
module axi_mem_ram #(
  parameter int    DATA_WIDTH = 16,
  parameter int    DEPTH      = 4096,
  parameter string INIT_FILE  = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 burst memory responder; AXI_MEM_BACKPRESSURE_EN adds LFSR handshake throttling
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 16,
  parameter int    DEPTH      = 4096,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awid,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bid,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic                  s_axi_rid,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int                    SHIFT     = $clog2(DATA_WIDTH / 8);
  localparam int                    RAM_AW    = $clog2(DEPTH);
  localparam logic [2:0]            BEAT_SIZE = 3'(SHIFT);
  localparam logic [ADDR_WIDTH-1:0] IDX_LIMIT = ADDR_WIDTH'(DEPTH);

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == FIXED || burst == INCR) || size != BEAT_SIZE;
  endfunction

  logic gate_ready, gate_rvalid;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        rv_hold;

  // rv_hold keeps rvalid up once offered, so gating only delays a beat's first assertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= 16'hACE1;
      rv_hold <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rv_hold <= s_axi_rvalid & ~s_axi_rready;
    end
  end

  assign gate_ready  = lfsr[1:0] != 2'b00;
  assign gate_rvalid = (lfsr[3:2] != 2'b00) | rv_hold;
`else
  assign gate_ready  = 1'b1;
  assign gate_rvalid = 1'b1;
`endif

  rd_state_t             rd_state, rd_next;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [7:0]            rd_len, rd_cnt;
  logic                  rd_fixed, rd_bad, rd_err, ar_hs, r_hs;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign rd_err = rd_bad | (rd_idx >= IDX_LIMIT);
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign r_hs   = s_axi_rvalid & s_axi_rready;

  always_comb begin
    rd_next       = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = OKAY;
    s_axi_rdata   = '0;
    case (rd_state)
      RD_IDLE: begin
        s_axi_arready = gate_ready;
        if (s_axi_arvalid && gate_ready) rd_next = RD_DATA;
      end
      RD_DATA: begin
        s_axi_rvalid = gate_rvalid;
        s_axi_rlast  = rd_cnt == rd_len;
        s_axi_rresp  = rd_err ? SLVERR : OKAY;
        s_axi_rdata  = rd_err ? '0 : ram_rdata;
        if (gate_rvalid && s_axi_rready && s_axi_rlast) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      rd_idx    <= '0;
      rd_len    <= '0;
      rd_cnt    <= '0;
      rd_fixed  <= 1'b0;
      rd_bad    <= 1'b0;
      s_axi_rid <= 1'b0;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rd_idx    <= s_axi_araddr >> SHIFT;
        rd_len    <= s_axi_arlen;
        rd_cnt    <= '0;
        rd_fixed  <= s_axi_arburst == FIXED;
        rd_bad    <= burst_bad(s_axi_arburst, s_axi_arsize);
        s_axi_rid <= s_axi_arid;
      end else if (r_hs) begin
        rd_cnt <= rd_cnt + 8'd1;
        if (!rd_fixed) rd_idx <= rd_idx + ADDR_WIDTH'(1);
      end
    end
  end

  wr_state_t             wr_state, wr_next;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [7:0]            wr_len, wr_cnt;
  logic                  wr_fixed, wr_bad, wr_err, wr_oob, wr_final, aw_hs, w_hs, ram_we;

  assign wr_oob   = wr_idx >= IDX_LIMIT;
  assign wr_final = wr_cnt == wr_len;
  assign aw_hs    = s_axi_awvalid & s_axi_awready;
  assign w_hs     = s_axi_wvalid & s_axi_wready;
  assign ram_we   = w_hs & ~wr_bad & ~wr_oob;

  always_comb begin
    wr_next       = wr_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = OKAY;
    case (wr_state)
      WR_IDLE: begin
        s_axi_awready = gate_ready;
        if (s_axi_awvalid && gate_ready) wr_next = WR_DATA;
      end
      WR_DATA: begin
        s_axi_wready = gate_ready;
        if (s_axi_wvalid && gate_ready && wr_final) wr_next = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = wr_err ? SLVERR : OKAY;
        if (s_axi_bready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  // The burst length, not wlast, ends the data phase; a misplaced wlast only flags the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      wr_idx    <= '0;
      wr_len    <= '0;
      wr_cnt    <= '0;
      wr_fixed  <= 1'b0;
      wr_bad    <= 1'b0;
      wr_err    <= 1'b0;
      s_axi_bid <= 1'b0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        wr_idx    <= s_axi_awaddr >> SHIFT;
        wr_len    <= s_axi_awlen;
        wr_cnt    <= '0;
        wr_fixed  <= s_axi_awburst == FIXED;
        wr_bad    <= burst_bad(s_axi_awburst, s_axi_awsize);
        wr_err    <= 1'b0;
        s_axi_bid <= s_axi_awid;
      end else if (w_hs) begin
        wr_cnt <= wr_cnt + 8'd1;
        if (!wr_fixed) wr_idx <= wr_idx + ADDR_WIDTH'(1);
        if (wr_bad || wr_oob || (s_axi_wlast != wr_final)) wr_err <= 1'b1;
      end
    end
  end

  axi_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_idx[RAM_AW-1:0]),
    .wdata(s_axi_wdata),
    .raddr(rd_idx[RAM_AW-1:0]),
    .rdata(ram_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - randomized bench for axi_mem_slave against an array-based memory model
module tb_axi_mem_slave;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awid = 1'b0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'd1;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [15:0] s_axi_wdata = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bid;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arid = 1'b0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'd1;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [15:0] s_axi_rdata;
  logic        s_axi_rid;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  axi_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_mem [DEPTH];
  bit          model_known [DEPTH];
  logic [15:0] wd [256];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b00 || burst == 2'b01) && size == 3'd1;
  endfunction

  function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int i);
    return int'(addr >> 1) + ((burst == 2'b01) ? i : 0);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input logic id, input int last_beat);
    int t, idx;
    bit err;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size;
    s_axi_awburst = burst; s_axi_awid = id; s_axi_awprot = 3'($urandom); s_axi_awvalid = 1'b1;
    #1; t = 0;
    while (!s_axi_awready && t < 50) begin @(negedge clk); #1; t++; end
    expect_eq("aw_ready", s_axi_awready, 1);
    @(posedge clk); #1; s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      s_axi_wdata = wd[i]; s_axi_wlast = (i == last_beat); s_axi_wvalid = 1'b1;
      #1; t = 0;
      while (!s_axi_wready && t < 50) begin @(negedge clk); #1; t++; end
      expect_eq("w_ready", s_axi_wready, 1);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    err = !burst_ok(burst, size) || last_beat != len;
    for (int i = 0; i <= len; i++) begin
      idx = beat_idx(addr, burst, i);
      if (idx >= DEPTH) err = 1'b1;
      else if (burst_ok(burst, size)) begin
        model_mem[idx] = wd[i];
        model_known[idx] = 1'b1;
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    s_axi_bready = 1'b1;
    #1; t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge clk); #1; t++; end
    expect_eq("b_valid", s_axi_bvalid, 1);
    expect_eq("b_resp", s_axi_bresp, err ? 2 : 0);
    expect_eq("b_id", s_axi_bid, id);
    @(posedge clk); #1; s_axi_bready = 1'b0;
  endtask

  // mode 0: rready always high, 1: random rready, 2: five-cycle stall on beat 1
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic id, input int mode);
    int t, i, stalled, idx;
    bit err;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size;
    s_axi_arburst = burst; s_axi_arid = id; s_axi_arprot = 3'($urandom); s_axi_arvalid = 1'b1;
    #1; t = 0;
    while (!s_axi_arready && t < 50) begin @(negedge clk); #1; t++; end
    expect_eq("ar_ready", s_axi_arready, 1);
    @(posedge clk); #1; s_axi_arvalid = 1'b0;
    i = 0; t = 0; stalled = 0;
    while (i <= len && t < 1000) begin
      @(negedge clk);
      if (mode == 1) s_axi_rready = $urandom_range(0, 2) != 0;
      else if (mode == 2 && i == 1 && stalled < 5) begin s_axi_rready = 1'b0; stalled++; end
      else s_axi_rready = 1'b1;
      #1;
      if (t == 0) expect_eq("r_first_valid", s_axi_rvalid, 1);
      if (s_axi_rvalid) begin
        idx = beat_idx(addr, burst, i);
        err = !burst_ok(burst, size) || idx >= DEPTH;
        expect_eq("r_resp", s_axi_rresp, err ? 2 : 0);
        expect_eq("r_last", s_axi_rlast, i == len);
        expect_eq("r_id", s_axi_rid, id);
        if (err) expect_eq("r_data_err", s_axi_rdata, 0);
        else if (model_known[idx]) expect_eq("r_data", s_axi_rdata, model_mem[idx]);
        if (s_axi_rready) i++;
      end
      t++;
    end
    expect_eq("r_beats", i, len + 1);
    @(posedge clk); #1; s_axi_rready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, lb;
    logic [31:0] a;
    logic [1:0] b;

    repeat (3) @(negedge clk);
    expect_eq("rst_awready", s_axi_awready, 1);
    expect_eq("rst_arready", s_axi_arready, 1);
    expect_eq("rst_wready", s_axi_wready, 0);
    expect_eq("rst_bvalid", s_axi_bvalid, 0);
    expect_eq("rst_rvalid", s_axi_rvalid, 0);
    expect_eq("rst_rlast", s_axi_rlast, 0);
    expect_eq("rst_bresp", s_axi_bresp, 0);
    expect_eq("rst_rresp", s_axi_rresp, 0);
    expect_eq("rst_bid", s_axi_bid, 0);
    expect_eq("rst_rid", s_axi_rid, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) wd[i] = 16'(i + 1);
    axi_write(32'h0, 3, 2'b01, 3'd1, 1'b0, 3);
    axi_read(32'h0, 3, 2'b01, 3'd1, 1'b1, 0);

    wd[0] = 16'hA; wd[1] = 16'hB; wd[2] = 16'hC; wd[3] = 16'hD;
    axi_write(32'h1000, 3, 2'b01, 3'd1, 1'b1, 3);
    axi_read(32'h1000, 3, 2'b01, 3'd1, 1'b0, 0);

    for (int i = 0; i < 252; i++) wd[i] = 16'($urandom);
    axi_write(32'h8, 251, 2'b01, 3'd1, 1'b0, 251);

    for (int i = 0; i < 4; i++) wd[i] = 16'h7700 + 16'(i);
    axi_write(32'h20, 3, 2'b01, 3'd1, 1'b1, 2);
    axi_read(32'h20, 3, 2'b01, 3'd1, 1'b1, 0);

    wd[0] = 16'h5A5A;
    axi_write(32'(2 * DEPTH - 2), 0, 2'b01, 3'd1, 1'b0, 0);
    axi_read(32'(2 * DEPTH - 2), 1, 2'b01, 3'd1, 1'b0, 0);
    wd[0] = 16'hC3C3; wd[1] = 16'hFFFF;
    axi_write(32'(2 * DEPTH - 2), 1, 2'b01, 3'd1, 1'b1, 1);
    axi_read(32'(2 * DEPTH - 4), 1, 2'b01, 3'd1, 1'b1, 0);

    for (int i = 0; i < 4; i++) wd[i] = 16'hDEAD;
    axi_write(32'h40, 3, 2'b10, 3'd1, 1'b0, 3);
    axi_write(32'h48, 1, 2'b01, 3'd0, 1'b1, 1);
    axi_read(32'h40, 7, 2'b01, 3'd1, 1'b0, 0);
    axi_read(32'h40, 3, 2'b10, 3'd1, 1'b1, 0);
    axi_read(32'h40, 1, 2'b01, 3'd2, 1'b0, 0);
    axi_read(32'h60, 7, 2'b00, 3'd1, 1'b1, 0);

    axi_read(32'h80, 7, 2'b01, 3'd1, 1'b1, 2);

    for (int i = 0; i < 4; i++) wd[i] = 16'($urandom);
    fork
      axi_write(32'h400, 3, 2'b01, 3'd1, 1'b1, 3);
      axi_read(32'h10, 5, 2'b01, 3'd1, 1'b0, 0);
    join
    axi_read(32'h400, 3, 2'b01, 3'd1, 1'b0, 1);

    @(negedge clk);
    s_axi_araddr = 32'h0; s_axi_arlen = 8'd3; s_axi_arsize = 3'd1;
    s_axi_arburst = 2'b01; s_axi_arid = 1'b1; s_axi_arvalid = 1'b1;
    #1; expect_eq("rst_ar_ready", s_axi_arready, 1);
    @(posedge clk); #1; s_axi_arvalid = 1'b0;
    @(negedge clk); s_axi_rready = 1'b1;
    #1; expect_eq("rst_beat0", s_axi_rdata, model_mem[0]);
    @(posedge clk);
    @(negedge clk);
    #1; expect_eq("rst_beat1", s_axi_rdata, model_mem[1]);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    expect_eq("midrst_rvalid", s_axi_rvalid, 0);
    expect_eq("midrst_arready", s_axi_arready, 1);
    expect_eq("midrst_rlast", s_axi_rlast, 0);
    @(negedge clk); rst = 1'b0; s_axi_rready = 1'b0;
    axi_read(32'h0, 3, 2'b01, 3'd1, 1'b1, 0);

    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(0, 7);
      a = 32'($urandom_range(0, 511)) << 1;
      b = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      lb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len + 1) : len;
      for (int i = 0; i <= len; i++) wd[i] = 16'($urandom);
      axi_write(a, len, b, 3'd1, 1'($urandom), lb);
      len = $urandom_range(0, 7);
      a = 32'($urandom_range(0, 511)) << 1;
      b = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      axi_read(a, len, b, 3'd1, 1'($urandom), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
